// File: rtl/phys_regfile_scoreboard_if.sv
// phys_regfile_scoreboard_if: read, allocate and writeback bundle between the
// reservation station, dispatch, the FUs and the physical register file.
interface phys_regfile_scoreboard_if #(
    parameter int NUM_PREGS = 64,
    parameter int PTAG_W    = 6,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 3,
    parameter int NUM_AL    = 2
);
    logic [NUM_RD-1:0]        rd_req_valid;
    logic [NUM_RD*PTAG_W-1:0] rd_req_tag;
    logic [NUM_RD*DATA_W-1:0] rd_resp_data;
    logic [NUM_RD-1:0]        rd_resp_rdy;
    logic [NUM_AL-1:0]        alloc_valid;
    logic [NUM_AL*PTAG_W-1:0] alloc_tag;
    logic [NUM_WR-1:0]        wb_valid;
    logic [NUM_WR*PTAG_W-1:0] wb_tag;
    logic [NUM_WR*DATA_W-1:0] wb_data;
    logic [NUM_PREGS-1:0]     phy_reg_rdy;
    logic [PTAG_W:0]          busy_count;
    logic                     err_wb_conflict;

    modport master (
        output rd_req_valid, rd_req_tag, alloc_valid, alloc_tag, wb_valid, wb_tag, wb_data,
        input  rd_resp_data, rd_resp_rdy, phy_reg_rdy, busy_count, err_wb_conflict
    );
    modport slave (
        input  rd_req_valid, rd_req_tag, alloc_valid, alloc_tag, wb_valid, wb_tag, wb_data,
        output rd_resp_data, rd_resp_rdy, phy_reg_rdy, busy_count, err_wb_conflict
    );
endinterface

// File: rtl/phys_regfile_scoreboard.sv
// phys_regfile_scoreboard: physical register file with per-tag ready scoreboard.
// Optional PRF_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module phys_regfile_scoreboard #(
    parameter int NUM_PREGS = 64,
    parameter int PTAG_W    = 6,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 3,
    parameter int NUM_AL    = 2
) (
    input logic                      clk,
    input logic                      reset,
    phys_regfile_scoreboard_if.slave bus
);
    logic [DATA_W-1:0]    data_q [NUM_PREGS];
    logic [NUM_PREGS-1:0] rdy_q, rdy_d;
    logic [PTAG_W:0]      busy_q, busy_d;
    logic                 err_q, err_d;

    // Alloc is applied after writeback so a same-cycle alloc leaves the tag pending.
    always_comb begin
        rdy_d = rdy_q;
        err_d = err_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wb_valid[i])
                rdy_d[bus.wb_tag[i*PTAG_W +: PTAG_W]] = 1'b1;
            for (int j = i + 1; j < NUM_WR; j++)
                if (bus.wb_valid[i] && bus.wb_valid[j] &&
                    bus.wb_tag[i*PTAG_W +: PTAG_W] == bus.wb_tag[j*PTAG_W +: PTAG_W] &&
                    bus.wb_tag[i*PTAG_W +: PTAG_W] != '0)
                    err_d = 1'b1;
        end
        for (int j = 0; j < NUM_AL; j++)
            if (bus.alloc_valid[j])
                rdy_d[bus.alloc_tag[j*PTAG_W +: PTAG_W]] = 1'b0;
        rdy_d[0] = 1'b1;
    end

    always_comb begin
        busy_d = busy_q;
        for (int t = 1; t < NUM_PREGS; t++)
            busy_d = busy_d + (PTAG_W+1)'(rdy_q[t] & ~rdy_d[t]) - (PTAG_W+1)'(~rdy_q[t] & rdy_d[t]);
    end

    // Ports are visited high to low so the lowest-index writer lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q  <= '1;
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int t = 0; t < NUM_PREGS; t++)
                data_q[t] <= '0;
        end else begin
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            for (int i = NUM_WR - 1; i >= 0; i--)
                if (bus.wb_valid[i] && bus.wb_tag[i*PTAG_W +: PTAG_W] != '0)
                    data_q[bus.wb_tag[i*PTAG_W +: PTAG_W]] <= bus.wb_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        bus.rd_resp_data = '0;
        bus.rd_resp_rdy  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.rd_req_valid[k]) begin
                bus.rd_resp_data[k*DATA_W +: DATA_W] = data_q[bus.rd_req_tag[k*PTAG_W +: PTAG_W]];
                bus.rd_resp_rdy[k] = rdy_q[bus.rd_req_tag[k*PTAG_W +: PTAG_W]];
`ifdef PRF_WB_BYPASS_EN
                for (int i = NUM_WR - 1; i >= 0; i--)
                    if (bus.wb_valid[i] && bus.rd_req_tag[k*PTAG_W +: PTAG_W] != '0 &&
                        bus.wb_tag[i*PTAG_W +: PTAG_W] == bus.rd_req_tag[k*PTAG_W +: PTAG_W]) begin
                        bus.rd_resp_data[k*DATA_W +: DATA_W] = bus.wb_data[i*DATA_W +: DATA_W];
                        bus.rd_resp_rdy[k] = 1'b1;
                    end
`endif
            end
        end
    end

    assign bus.phy_reg_rdy     = rdy_q;
    assign bus.busy_count      = busy_q;
    assign bus.err_wb_conflict = err_q;
endmodule

// File: tb/tb_phys_regfile_scoreboard.sv
// tb_phys_regfile_scoreboard: directed table, corner sequences and randomized
// traffic checked against an array-based model of the register file.
module tb_phys_regfile_scoreboard;
    logic clk, reset;
    int   tests, fails;

    phys_regfile_scoreboard_if bus ();
    phys_regfile_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_data [64];
    logic [63:0] m_rdy;
    logic        m_err;

    typedef struct packed {
        logic [1:0]  av;
        logic [11:0] at;
        logic [2:0]  wv;
        logic [17:0] wt;
        logic [95:0] wd;
        logic [5:0]  probe;
        logic [31:0] ed;
        logic        erdy;
        logic [6:0]  eb;
        logic        ee;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] av, input logic [11:0] at, input logic [2:0] wv,
                         input logic [17:0] wt, input logic [95:0] wd,
                         input logic [2:0] rv, input logic [17:0] rt);
        bus.alloc_valid  = av;
        bus.alloc_tag    = at;
        bus.wb_valid     = wv;
        bus.wb_tag       = wt;
        bus.wb_data      = wd;
        bus.rd_req_valid = rv;
        bus.rd_req_tag   = rt;
    endtask

    // Expected read responses from model state plus the optional bypass rule.
    task automatic exp_read(output logic [95:0] ed, output logic [2:0] er);
        ed = '0;
        er = '0;
        for (int k = 0; k < 3; k++) begin
            int  t;
            bit  hit;
            t   = int'(bus.rd_req_tag[k*6 +: 6]);
            hit = 1'b0;
            if (bus.rd_req_valid[k]) begin
                ed[k*32 +: 32] = m_data[t];
                er[k]          = m_rdy[t];
`ifdef PRF_WB_BYPASS_EN
                for (int i = 0; i < 3; i++)
                    if (!hit && t != 0 && bus.wb_valid[i] && int'(bus.wb_tag[i*6 +: 6]) == t) begin
                        hit            = 1'b1;
                        ed[k*32 +: 32] = bus.wb_data[i*32 +: 32];
                        er[k]          = 1'b1;
                    end
`endif
            end
        end
    endtask

    task automatic m_step();
        logic [63:0] wrote;
        int t;
        if (reset) begin
            m_rdy = '1;
            m_err = 1'b0;
            for (int i = 0; i < 64; i++) m_data[i] = '0;
            return;
        end
        wrote = '0;
        for (int i = 0; i < 3; i++) begin
            t = int'(bus.wb_tag[i*6 +: 6]);
            if (bus.wb_valid[i] && t != 0) begin
                if (wrote[t]) m_err = 1'b1;
                else begin
                    wrote[t]  = 1'b1;
                    m_data[t] = bus.wb_data[i*32 +: 32];
                    m_rdy[t]  = 1'b1;
                end
            end
        end
        for (int j = 0; j < 2; j++) begin
            t = int'(bus.alloc_tag[j*6 +: 6]);
            if (bus.alloc_valid[j] && t != 0) m_rdy[t] = 1'b0;
        end
    endtask

    task automatic cycle(input bit chk_rd);
        logic [95:0] ed;
        logic [2:0]  er;
        #1;
        if (chk_rd) begin
            exp_read(ed, er);
            chk("rd_data", 128'(bus.rd_resp_data), 128'(ed));
            chk("rd_rdy", 128'(bus.rd_resp_rdy), 128'(er));
        end
        m_step();
        @(posedge clk);
        #1;
        chk("phy_reg_rdy", 128'(bus.phy_reg_rdy), 128'(m_rdy));
        chk("busy_count", 128'(bus.busy_count), 128'($countones(~m_rdy)));
        chk("err_wb_conflict", 128'(bus.err_wb_conflict), 128'(m_err));
        @(negedge clk);
    endtask

    function automatic logic [5:0] rtag();
        return ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        tbl[0] = '{2'b11, {6'd41, 6'd40}, 3'b000, 18'd0, 96'd0, 6'd40, 32'd0, 1'b0, 7'd2, 1'b0};
        tbl[1] = '{2'b00, 12'd0, 3'b001, {6'd0, 6'd0, 6'd40}, {32'd0, 32'd0, 32'hDEADBEEF},
                   6'd40, 32'hDEADBEEF, 1'b1, 7'd1, 1'b0};
        tbl[2] = '{2'b01, {6'd0, 6'd50}, 3'b010, {6'd0, 6'd50, 6'd0}, {32'd0, 32'h1234, 32'd0},
                   6'd50, 32'h1234, 1'b0, 7'd2, 1'b0};
        tbl[3] = '{2'b00, 12'd0, 3'b101, {6'd7, 6'd0, 6'd7}, {32'hB, 32'd0, 32'hA},
                   6'd7, 32'hA, 1'b1, 7'd2, 1'b1};
        tbl[4] = '{2'b00, 12'd0, 3'b010, 18'd0, {32'd0, 32'hFFFF, 32'd0},
                   6'd0, 32'd0, 1'b1, 7'd2, 1'b1};
        tbl[5] = '{2'b11, {6'd41, 6'd41}, 3'b000, 18'd0, 96'd0, 6'd41, 32'd0, 1'b0, 7'd2, 1'b1};
        tbl[6] = '{2'b00, 12'd0, 3'b011, {6'd0, 6'd50, 6'd41}, {32'd0, 32'h99, 32'h77},
                   6'd50, 32'h99, 1'b1, 7'd0, 1'b1};
        tbl[7] = '{2'b11, {6'd0, 6'd0}, 3'b000, 18'd0, 96'd0, 6'd0, 32'd0, 1'b1, 7'd0, 1'b1};

        reset = 1'b1;
        drive('0, '0, '0, '0, '0, '0, '0);
        cycle(0);
        cycle(0);
        reset = 1'b0;

        drive('0, '0, '0, '0, '0, 3'b111, {6'd63, 6'd5, 6'd0});
        #1;
        chk("reset_rd_data", 128'(bus.rd_resp_data), 128'd0);
        chk("reset_rd_rdy", 128'(bus.rd_resp_rdy), 128'(3'b111));
        chk("reset_phy_rdy", 128'(bus.phy_reg_rdy), 128'({64{1'b1}}));
        chk("reset_busy", 128'(bus.busy_count), 128'd0);
        cycle(1);

        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].av, tbl[r].at, tbl[r].wv, tbl[r].wt, tbl[r].wd, 3'b000, 18'd0);
            cycle(1);
            drive('0, '0, '0, '0, '0, 3'b001, {12'd0, tbl[r].probe});
            #1;
            chk($sformatf("row%0d_data", r), 128'(bus.rd_resp_data[31:0]), 128'(tbl[r].ed));
            chk($sformatf("row%0d_rdy", r), 128'(bus.rd_resp_rdy[0]), 128'(tbl[r].erdy));
            chk($sformatf("row%0d_busy", r), 128'(bus.busy_count), 128'(tbl[r].eb));
            chk($sformatf("row%0d_err", r), 128'(bus.err_wb_conflict), 128'(tbl[r].ee));
            cycle(1);
        end

        // Writeback and alloc of tag 33 while port 1 reads it in the same cycle.
        drive(2'b01, {6'd0, 6'd33}, 3'b001, {6'd0, 6'd0, 6'd33}, {32'd0, 32'd0, 32'h55},
              3'b010, {6'd0, 6'd33, 6'd0});
        #1;
`ifdef PRF_WB_BYPASS_EN
        chk("bypass_data", 128'(bus.rd_resp_data[63:32]), 128'h55);
`else
        chk("bypass_data", 128'(bus.rd_resp_data[63:32]), 128'h0);
`endif
        chk("bypass_rdy", 128'(bus.rd_resp_rdy[1]), 128'd1);
        cycle(1);
        drive('0, '0, '0, '0, '0, 3'b010, {6'd0, 6'd33, 6'd0});
        #1;
        chk("after_wb_data", 128'(bus.rd_resp_data[63:32]), 128'h55);
        chk("after_wb_rdy", 128'(bus.rd_resp_rdy[1]), 128'd0);
        chk("after_wb_busy", 128'(bus.busy_count), 128'd1);
        cycle(1);

        for (int n = 0; n < 400; n++) begin
            logic [11:0] at;
            logic [17:0] wt, rt;
            logic [95:0] wd;
            for (int k = 0; k < 3; k++) begin
                wt[k*6 +: 6]   = rtag();
                wd[k*32 +: 32] = $urandom;
            end
            for (int k = 0; k < 3; k++)
                rt[k*6 +: 6] = ($urandom % 2) ? wt[($urandom % 3)*6 +: 6] : rtag();
            at    = {rtag(), rtag()};
            reset = ($urandom_range(0, 199) == 0);
            drive(2'($urandom), at, 3'($urandom), wt, wd, 3'($urandom), rt);
            cycle(!reset);
        end
        reset = 1'b0;

        // Reset one cycle after allocating 10 and 11 with a pending conflict flag.
        drive(2'b11, {6'd11, 6'd10}, 3'b011, {6'd0, 6'd9, 6'd9}, {32'd0, 32'h2, 32'h1},
              3'b000, 18'd0);
        cycle(1);
        chk("pre_reset_err", 128'(bus.err_wb_conflict), 128'd1);
        reset = 1'b1;
        drive('0, '0, '0, '0, '0, '0, '0);
        cycle(0);
        reset = 1'b0;
        #1;
        chk("midreset_phy_rdy", 128'(bus.phy_reg_rdy), 128'({64{1'b1}}));
        chk("midreset_busy", 128'(bus.busy_count), 128'd0);
        chk("midreset_err", 128'(bus.err_wb_conflict), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/phys_regfile_scoreboard.md
Name: phys_regfile_scoreboard

Overview:
- Physical register file plus per-register ready scoreboard. It is the responder for the reservation station's three combinational register-read request ports, and the producer of the 64-bit `phy_reg_rdy` vector.
- Dispatch marks newly allocated destination tags busy. FU writeback writes data and marks tags ready.
- Sits between dispatch/rename, the reservation station and the complete stage.

Parameters:
- NUM_PREGS, 64, number of physical registers; tag 0 is the hardwired zero register.
- PTAG_W, 6, physical tag width; must satisfy 2**PTAG_W == NUM_PREGS.
- DATA_W, 32, register data width.
- NUM_RD, 3, read ports; one per issue lane.
- NUM_WR, 3, writeback ports; one per FU.
- NUM_AL, 2, allocation ports; dispatch width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rd_req_valid  input  NUM_RD  read request valid per port
- rd_req_tag  input  NUM_RD*PTAG_W  read tag per port; port k uses bits [k*PTAG_W +: PTAG_W]
- rd_resp_data  output  NUM_RD*DATA_W  read data per port; combinational
- rd_resp_rdy  output  NUM_RD  ready bit of the requested tag; combinational
- alloc_valid  input  NUM_AL  dispatch allocates a destination tag
- alloc_tag  input  NUM_AL*PTAG_W  tag to mark busy
- wb_valid  input  NUM_WR  FU result valid
- wb_tag  input  NUM_WR*PTAG_W  result destination tag
- wb_data  input  NUM_WR*DATA_W  result data
- phy_reg_rdy  output  NUM_PREGS  registered ready vector; bit t = tag t ready
- busy_count  output  PTAG_W+1  registered count of not-ready tags
- err_wb_conflict  output  1  sticky; set when two wb ports target the same nonzero tag in one cycle

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - all data = 0; phy_reg_rdy = all ones; busy_count = 0; err_wb_conflict = 0.
  - Reset mid-operation discards all pending busy state.
- Tag 0:
  - reads always return data 0, rdy 1.
  - alloc and wb to tag 0 are ignored.
  - phy_reg_rdy[0] is constant 1.
- Read (combinational, zero latency):
  - port k returns data[tag] and rdy[tag] from the registered state.
  - When rd_req_valid[k]=0, rd_resp_data=0 and rd_resp_rdy=0.
- Allocation:
  - alloc_valid[j] at edge N clears rdy[alloc_tag[j]] from N+1.
  - Data is unchanged.
  - Allocating an already-busy tag is legal; it stays busy and busy_count does not double-count.
- Writeback:
  - wb_valid[i] at edge N writes wb_data[i] to data[wb_tag[i]] and sets rdy from N+1. Latency is 1 cycle.
- Same-tag simultaneous events, in priority order:
  - alloc and wb to the same tag in the same cycle: data is written, rdy ends 0 (alloc wins; the new producer is pending).
  - two or more wb ports to the same tag: lowest port index wins for data; err_wb_conflict sets and stays set until reset.
  - two alloc ports to the same tag: tag busy; counted once.
- busy_count:
  - equals the popcount of ~phy_reg_rdy at every cycle.
  - Maintained incrementally: +newly-busy −newly-ready, computed from the unique next-state transitions.
  - Maximum value is NUM_PREGS−1.
- phy_reg_rdy is a direct register output; no combinational path from inputs.

Optional Feature:
- Macro: PRF_WB_BYPASS_EN.
- When defined:
  - a read whose tag matches a same-cycle valid wb tag (lowest wb port index wins) returns wb_data with rd_resp_rdy=1 combinationally;
  - an alloc to that same tag in that cycle does not suppress the bypass.
  - phy_reg_rdy timing is unchanged.
- When undefined: reads see only registered state; the new value is visible one cycle after writeback.

Test Plan:
- Reset, then read tags 0, 5 and 63 on ports 0–2 -> data 0, rd_resp_rdy=3'b111, phy_reg_rdy all ones, busy_count=0.
- alloc tags 40 and 41 at cycle 1 -> cycle 2: phy_reg_rdy[40]=phy_reg_rdy[41]=0, busy_count=2. wb tag 40 data 0xDEADBEEF at cycle 3 -> cycle 4: read tag 40 returns 0xDEADBEEF, rdy 1; busy_count=1.
- Same cycle: alloc tag 50 and wb tag 50 data 0x1234 -> next cycle phy_reg_rdy[50]=0, read returns 0x1234 with rdy 0, busy_count incremented by 1.
- wb ports 0 and 2 both target tag 7 (data 0xA, 0xB) -> tag 7 holds 0xA, err_wb_conflict=1 and stays 1; wb to tag 0 with 0xFFFF -> read tag 0 still 0.
- With PRF_WB_BYPASS_EN: wb tag 33 data 0x55 while port 1 reads tag 33 -> rd_resp_data port 1 = 0x55, rdy 1 in the same cycle. Without the macro: old value that cycle, 0x55 the next.
- Alloc tags 10 and 11, assert reset the following cycle -> all ready, busy_count=0, err_wb_conflict=0.
